// File: rtl/mem_wb_stage_if.sv
// EX/MEM-side inputs, MEM/WB-side outputs and board I/O of the memory stage.
// No handshake: one instruction (or zero bubble) per cycle, no backpressure.
interface mem_wb_stage_if;
   logic        RegWrite_in;
   logic        MemWrite_in;
   logic        MemRead_in;
   logic [1:0]  MemtoReg_in;
   logic [31:0] PC_in;
   logic [31:0] ALUout_in;
   logic [31:0] instruction_in;
   logic [1:0]  RegDst_in;
   logic [31:0] DataBusB_in;
   logic [7:0]  switch_in;
   logic        RegWrite_wb;
   logic [4:0]  WriteReg_wb;
   logic [31:0] WriteData_wb;
   logic [31:0] MemReadData;
   logic [7:0]  led;
   logic        irq;

   modport master (
      output RegWrite_in, MemWrite_in, MemRead_in, MemtoReg_in, PC_in, ALUout_in,
             instruction_in, RegDst_in, DataBusB_in, switch_in,
      input  RegWrite_wb, WriteReg_wb, WriteData_wb, MemReadData, led, irq
   );

   modport slave (
      input  RegWrite_in, MemWrite_in, MemRead_in, MemtoReg_in, PC_in, ALUout_in,
             instruction_in, RegDst_in, DataBusB_in, switch_in,
      output RegWrite_wb, WriteReg_wb, WriteData_wb, MemReadData, led, irq
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MIPS MEM stage (data RAM, timer, LED, switches, systick) plus MEM/WB register.
// Loads are combinational, WB fields have one-cycle latency; no stall, no backpressure.
module mem_wb_stage #(
   parameter int          RAM_WORDS   = 256,
   parameter int          RAM_AW      = 8,
   parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
   input  logic          clk,
   input  logic          reset,
   mem_wb_stage_if.slave bus
);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

   logic [31:0] ram [RAM_WORDS];
   logic [31:0] th, tl, systick;
   logic [2:0]  tcon;
   logic [7:0]  led_q;
   logic        irq_q;

   logic [31:0] addr_word;
   logic [RAM_AW-1:0] ram_idx;
   logic        is_ram, sel_th, sel_tl, sel_tcon, sel_led, sel_sw, sel_tick;
   logic        wr;
   logic [31:0] rd_data;
   logic        tl_wrap, ovf_set;
   logic [31:0] wb_data;
   logic [4:0]  wb_reg;
   logic        unused_instr;

   assign addr_word = {bus.ALUout_in[31:2], 2'b00};
   assign ram_idx   = bus.ALUout_in[RAM_AW+1:2];
   assign is_ram    = bus.ALUout_in < RAM_BYTES;
   assign sel_th    = addr_word == PERIPH_BASE;
   assign sel_tl    = addr_word == PERIPH_BASE + 32'h04;
   assign sel_tcon  = addr_word == PERIPH_BASE + 32'h08;
   assign sel_led   = addr_word == PERIPH_BASE + 32'h0C;
   assign sel_sw    = addr_word == PERIPH_BASE + 32'h10;
   assign sel_tick  = addr_word == PERIPH_BASE + 32'h14;
   assign wr        = bus.MemWrite_in;

   // Only the rt/rd fields of the instruction matter here.
   assign unused_instr = ^{bus.instruction_in[31:21], bus.instruction_in[10:0]};

   always_comb begin
      rd_data = 32'b0;
      if (is_ram)        rd_data = ram[ram_idx];
      else if (sel_th)   rd_data = th;
      else if (sel_tl)   rd_data = tl;
      else if (sel_tcon) rd_data = {29'b0, tcon};
      else if (sel_led)  rd_data = {24'b0, led_q};
      else if (sel_sw)   rd_data = {24'b0, bus.switch_in};
      else if (sel_tick) rd_data = systick;
   end

   assign bus.MemReadData = bus.MemRead_in ? rd_data : 32'b0;

   // RAM has no reset so its contents survive a pipeline reset.
   always_ff @(posedge clk) begin
      if (wr && is_ram) ram[ram_idx] <= bus.DataBusB_in;
   end

   assign tl_wrap = tcon[0] && (tl == 32'hFFFF_FFFF);
   assign ovf_set = tl_wrap && tcon[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th      <= 32'b0;
         tl      <= 32'b0;
         tcon    <= 3'b0;
         led_q   <= 8'b0;
         irq_q   <= 1'b0;
         systick <= 32'b0;
      end else begin
         systick <= systick + 32'd1;
         irq_q   <= tcon[1] & tcon[2];
         if (wr && sel_th) th <= bus.DataBusB_in;
         if (wr && sel_led) led_q <= bus.DataBusB_in[7:0];
         if (wr && sel_tl)  tl <= bus.DataBusB_in;
         else if (tl_wrap)  tl <= th;
         else if (tcon[0])  tl <= tl + 32'd1;
         // A CPU write never masks an overflow that lands in the same cycle.
         if (wr && sel_tcon) tcon <= {bus.DataBusB_in[2] | ovf_set, bus.DataBusB_in[1:0]};
         else if (ovf_set)   tcon[2] <= 1'b1;
      end
   end

   assign bus.led = led_q;
   assign bus.irq = irq_q;

   always_comb begin
      case (bus.MemtoReg_in)
         2'b01:   wb_data = bus.MemReadData;
         2'b10:   wb_data = bus.PC_in + 32'd4;
         default: wb_data = bus.ALUout_in;
      endcase
      case (bus.RegDst_in)
         2'b00:   wb_reg = bus.instruction_in[20:16];
         2'b01:   wb_reg = bus.instruction_in[15:11];
         2'b10:   wb_reg = 5'd31;
         default: wb_reg = 5'd26;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.RegWrite_wb  <= 1'b0;
         bus.WriteReg_wb  <= 5'b0;
         bus.WriteData_wb <= 32'b0;
      end else begin
         bus.RegWrite_wb  <= bus.RegWrite_in;
         bus.WriteReg_wb  <= wb_reg;
         bus.WriteData_wb <= wb_data;
      end
   end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised and directed bench for mem_wb_stage against an in-bench behavioural model.
module tb_mem_wb_stage;
   localparam logic [31:0] PB = 32'h4000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_wb_stage_if bus();

   mem_wb_stage #(.RAM_WORDS(256), .RAM_AW(8), .PERIPH_BASE(PB)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   logic [31:0] m_ram [256];
   logic [31:0] m_th, m_tl, m_tick;
   logic [2:0]  m_tcon;
   logic [7:0]  m_led;
   logic        m_irq;
   logic        e_rw;
   logic [4:0]  e_wreg;
   logic [31:0] e_wdata;

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (a < 32'd1024) return m_ram[a[9:2]];
      if (w == PB)          return m_th;
      if (w == PB + 32'h04) return m_tl;
      if (w == PB + 32'h08) return {29'b0, m_tcon};
      if (w == PB + 32'h0C) return {24'b0, m_led};
      if (w == PB + 32'h10) return {24'b0, bus.switch_in};
      if (w == PB + 32'h14) return m_tick;
      return 32'b0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic rw, input logic mw, input logic mr, input logic [1:0] mtr,
                         input logic [1:0] rd, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] ins, input logic [31:0] d);
      bus.RegWrite_in = rw; bus.MemWrite_in = mw; bus.MemRead_in = mr;
      bus.MemtoReg_in = mtr; bus.RegDst_in = rd; bus.PC_in = pc;
      bus.ALUout_in = alu; bus.instruction_in = ins; bus.DataBusB_in = d;
   endtask

   // One clock of stimulus: check the load path, predict the edge, then check registered outputs.
   task automatic step();
      logic [31:0] a, d, rdv, n_th, n_tl, n_wd;
      logic [2:0]  n_tcon;
      logic [7:0]  n_led;
      logic [4:0]  n_wr;
      logic        ovf, ovf_irq, n_irq, wr;
      #1;
      a = bus.ALUout_in; d = bus.DataBusB_in; wr = bus.MemWrite_in;
      rdv = bus.MemRead_in ? m_read(a) : 32'b0;
      chk("mem_read_data", bus.MemReadData, rdv);
      case (bus.MemtoReg_in)
         2'b01:   n_wd = rdv;
         2'b10:   n_wd = bus.PC_in + 32'd4;
         default: n_wd = a;
      endcase
      case (bus.RegDst_in)
         2'b00:   n_wr = bus.instruction_in[20:16];
         2'b01:   n_wr = bus.instruction_in[15:11];
         2'b10:   n_wr = 5'd31;
         default: n_wr = 5'd26;
      endcase
      ovf = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
      ovf_irq = ovf && m_tcon[1];
      n_th = m_th; n_led = m_led; n_tl = m_tl; n_tcon = m_tcon;
      if (m_tcon[0]) n_tl = ovf ? m_th : m_tl + 32'd1;
      if (ovf_irq) n_tcon[2] = 1'b1;
      n_irq = m_tcon[1] & m_tcon[2];
      if (wr) begin
         if ({a[31:2], 2'b00} == PB)          n_th = d;
         if ({a[31:2], 2'b00} == PB + 32'h04) n_tl = d;
         if ({a[31:2], 2'b00} == PB + 32'h08) n_tcon = {d[2] | ovf_irq, d[1:0]};
         if ({a[31:2], 2'b00} == PB + 32'h0C) n_led = d[7:0];
      end
      @(posedge clk);
      #1;
      if (wr && a < 32'd1024) m_ram[a[9:2]] = d;
      m_th = n_th; m_tl = n_tl; m_tcon = n_tcon; m_led = n_led; m_irq = n_irq;
      m_tick = m_tick + 32'd1;
      e_rw = bus.RegWrite_in; e_wreg = n_wr; e_wdata = n_wd;
      chk("regwrite_wb", {31'b0, bus.RegWrite_wb}, {31'b0, e_rw});
      chk("writereg_wb", {27'b0, bus.WriteReg_wb}, {27'b0, e_wreg});
      chk("writedata_wb", bus.WriteData_wb, e_wdata);
      chk("led", {24'b0, bus.led}, {24'b0, m_led});
      chk("irq", {31'b0, bus.irq}, {31'b0, m_irq});
   endtask

   task automatic ld(input logic [31:0] a, input logic [31:0] exp, input string nm);
      set_in(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'b0, a, 32'b0, 32'b0);
      #1;
      chk(nm, bus.MemReadData, exp);
      step();
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d);
      set_in(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'b0, a, 32'b0, d);
      step();
   endtask

   task automatic idle();
      set_in(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'b0, 32'b0, 32'b0, 32'b0);
      step();
   endtask

   // Drops reset between edges, checks everything reads zero, releases on a falling edge.
   task automatic do_reset();
      reset = 1'b0;
      #1;
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_irq = 0; m_tick = 0;
      e_rw = 0; e_wreg = 0; e_wdata = 0;
      chk("rst_regwrite", {31'b0, bus.RegWrite_wb}, 32'd0);
      chk("rst_writereg", {27'b0, bus.WriteReg_wb}, 32'd0);
      chk("rst_writedata", bus.WriteData_wb, 32'd0);
      chk("rst_led", {24'b0, bus.led}, 32'd0);
      chk("rst_irq", {31'b0, bus.irq}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         if (k != 4) begin
            set_in(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'b0, PB + 32'(4 * k), 32'b0, 32'b0);
            #1;
            chk("rst_periph_read", bus.MemReadData, 32'd0);
         end
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      int kind;
      bus.switch_in = 8'h00;
      set_in(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'b0, 32'b0, 32'b0, 32'b0);
      #1;
      do_reset();

      for (int i = 0; i < 256; i++) st(32'(i * 4), $urandom);

      st(32'h10, 32'hDEAD_BEEF);
      set_in(1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 32'b0, 32'h13, 32'h0008_0000, 32'b0);
      step();
      chk("ram_load_data", bus.WriteData_wb, 32'hDEAD_BEEF);
      chk("ram_load_reg", {27'b0, bus.WriteReg_wb}, 32'd8);
      chk("ram_load_we", {31'b0, bus.RegWrite_wb}, 32'd1);

      bus.switch_in = 8'h3C;
      ld(PB + 32'h10, 32'h0000_003C, "switch_read");
      ld(32'h4000_0100, 32'h0, "unmapped_read");
      st(PB + 32'h10, 32'hFFFF_FFFF);
      ld(PB + 32'h10, 32'h0000_003C, "switch_after_store");

      set_in(1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 32'h40, 32'h0, 32'h0, 32'h0);
      step();
      chk("jal_data", bus.WriteData_wb, 32'h44);
      chk("jal_reg", {27'b0, bus.WriteReg_wb}, 32'd31);
      idle();
      chk("bubble_we", {31'b0, bus.RegWrite_wb}, 32'd0);
      ld(32'h0, m_ram[0], "bubble_ram0");

      st(PB + 32'h04, 32'd5);
      st(PB + 32'h0C, 32'hA5);
      st(PB + 32'h08, 32'd1);
      chk("led_before_reset", {24'b0, bus.led}, 32'hA5);
      #2;
      do_reset();
      ld(32'h10, 32'hDEAD_BEEF, "ram_after_reset");

      st(PB, 32'hFFFF_FFFD);
      st(PB + 32'h04, 32'hFFFF_FFFD);
      st(PB + 32'h08, 32'd3);
      ld(PB + 32'h04, 32'hFFFF_FFFD, "tl_start");
      ld(PB + 32'h04, 32'hFFFF_FFFE, "tl_inc1");
      ld(PB + 32'h04, 32'hFFFF_FFFF, "tl_inc2");
      chk("irq_pre", {31'b0, bus.irq}, 32'd0);
      ld(PB + 32'h08, 32'd7, "tcon_status");
      chk("irq_set", {31'b0, bus.irq}, 32'd1);
      st(PB + 32'h08, 32'd3);
      chk("irq_hold", {31'b0, bus.irq}, 32'd1);
      ld(PB + 32'h04, 32'hFFFF_FFFF, "tl_after_reload");
      chk("irq_drop", {31'b0, bus.irq}, 32'd0);

      st(PB + 32'h08, 32'd0);
      st(PB + 32'h04, 32'hFFFF_FFFE);
      st(PB + 32'h08, 32'd1);
      idle();
      st(PB + 32'h04, 32'd100);
      ld(PB + 32'h04, 32'd100, "tl_collision");

      st(PB + 32'h08, 32'd0);
      st(PB + 32'h04, 32'hFFFF_FFFF);
      st(PB + 32'h08, 32'd3);
      st(PB + 32'h08, 32'd3);
      ld(PB + 32'h08, 32'd7, "tcon_collision");
      st(PB + 32'h08, 32'd0);
      st(PB + 32'h04, 32'hFFFF_FFFF);
      st(PB + 32'h08, 32'd3);
      st(PB + 32'h08, 32'd1);
      ld(PB + 32'h08, 32'd5, "tcon_collision_keep");

      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 9);
         if (kind < 4)      a = $urandom_range(0, 1023);
         else if (kind < 9) a = PB + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
         else               a = ($urandom_range(0, 1) != 0) ? $urandom : PB + 32'h100;
         d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
         if (a[31:2] == PB[31:2] + 30'd2 && $urandom_range(0, 1) != 0) d = 32'(1 + 2 * $urandom_range(0, 1));
         bus.switch_in = 8'($urandom);
         if ($urandom_range(0, 7) == 0)
            set_in(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'b0, 32'b0, 32'b0, 32'b0);
         else
            set_in(1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom),
                   2'($urandom), $urandom, a, $urandom, d);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register.
- Consumes the EX/MEM control, ALU result, store data and instruction.
- Performs the data RAM and memory-mapped peripheral access: timer, LEDs, switches and system tick counter.
- Registers the write-back value, destination register number and control into the WB stage.

Parameters:
- RAM_WORDS, 256, data RAM depth in 32-bit words; must be a power of 2.
- RAM_AW, 8, word-address width; equals log2(RAM_WORDS).
- PERIPH_BASE, 32'h4000_0000, base address of the peripheral window.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RegWrite_in  in  1  register-file write enable from EX/MEM.
- MemWrite_in  in  1  store enable.
- MemRead_in  in  1  load enable.
- MemtoReg_in  in  2  write-back select: 00 ALU, 01 memory, 10 PC+4, 11 ALU.
- PC_in  in  32  PC of the instruction.
- ALUout_in  in  32  effective address or ALU result.
- instruction_in  in  32  instruction word.
- RegDst_in  in  2  destination select: 00 rt [20:16], 01 rd [15:11], 10 $31, 11 $26 (k0).
- DataBusB_in  in  32  store data.
- switch_in  in  8  board switches, already synchronised.
- RegWrite_wb  out  1  registered write enable.
- WriteReg_wb  out  5  registered destination register.
- WriteData_wb  out  32  registered write-back data.
- MemReadData  out  32  combinational load data, for MEM-stage forwarding.
- led  out  8  LED register.
- irq  out  1  timer interrupt request, registered.

Behaviour:
- Reset (reset low, async):
  - RegWrite_wb=0, WriteReg_wb=0, WriteData_wb=0, led=0, irq=0.
  - TH=0, TL=0, TCON=0, systick=0.
  - RAM contents are not cleared.
- Address decode uses ALUout_in; bits [1:0] are ignored (word access only).
  - RAM: ALUout_in < RAM_WORDS*4. Word index = ALUout_in[RAM_AW+1:2].
  - PERIPH_BASE+0x00 TH (R/W).
  - +0x04 TL (R/W).
  - +0x08 TCON[2:0] (R/W): bit0 enable, bit1 irq enable, bit2 irq status.
  - +0x0C LED[7:0] (R/W).
  - +0x10 switches (RO, zero-extended).
  - +0x14 systick (RO).
  - Any other address: reads return 0, writes are ignored.
- Read: combinational. MemReadData = decoded data when MemRead_in=1, else 0. It is valid in the same cycle as the EX/MEM outputs.
- Write: synchronous on the rising clk edge when MemWrite_in=1.
  - Writes to TL take effect next cycle.
  - Writes to RO registers are ignored.
  - TCON write stores bits [2:0] of DataBusB_in.
- Load and store asserted together: the read returns the old value; the write commits at the edge.
- Timer, each cycle with TCON[0]=1:
  - If TL==32'hFFFF_FFFF: TL<=TH, and TCON[2]<=1 if TCON[1]=1.
  - Otherwise TL<=TL+1.
  - Disabled: TL holds.
- irq <= TCON[1] & TCON[2] (one-cycle registered delay).
- Simultaneous events:
  - CPU write to TL in the same cycle as a timer increment or reload: the CPU write wins.
  - CPU write to TCON in the same cycle as an overflow: bits [1:0] come from the write; bit2 = written bit2 OR overflow set. An interrupt is never lost.
- systick increments every cycle, free-running, and wraps modulo 2^32.
- MEM/WB register, one-cycle latency, all fields registered on the rising edge:
  - WriteData_wb = ALUout_in for MemtoReg 00/11; MemReadData for 01; PC_in+4 (mod 2^32) for 10.
  - WriteReg_wb decoded from RegDst_in and instruction_in.
  - RegWrite_wb = RegWrite_in.
- There is no stall or flush input; bubbles arrive as all-zero EX/MEM contents. A zero bubble yields RegWrite_wb=0 and causes no memory write.

Test Plan:
- Reset mid-operation:
  - Stimulus: timer enabled, TL=5, LED=8'hA5; drop reset asynchronously between clock edges.
  - Response: all outputs and registers read 0 immediately; the RAM word written earlier is still readable after reset.
- RAM store/load:
  - Stimulus: store 32'hDEADBEEF to 0x0000_0010; next cycle load 0x0000_0013 with MemtoReg=01, RegDst=00, rt=8.
  - Response: one cycle later WriteData_wb=32'hDEADBEEF, WriteReg_wb=8, RegWrite_wb=1.
- Timer reload and irq:
  - Stimulus: TH=32'hFFFF_FFFD, TL=32'hFFFF_FFFD, TCON=3'b011.
  - Response: TL goes ...FE, ...FF, then reloads to ...FD; TCON[2]=1 after the reload edge; irq=1 one cycle later.
  - Follow-up: write TCON=3'b011 → irq drops one cycle after TCON[2] clears.
- Collisions:
  - TL write collision: write TL=100 on the overflow cycle → TL=100, not TH.
  - TCON collision: write TCON=3'b011 on the overflow cycle → TCON reads 3'b111.
- Peripheral and unmapped accesses:
  - switch_in=8'h3C, load PERIPH_BASE+0x10 → 32'h0000_003C.
  - Load 0x4000_0100 → 0.
  - Store to 0x4000_0010 → switch read is unchanged.
- Link write-back and bubble:
  - jal: PC_in=32'h0000_0040, MemtoReg=10, RegDst=10 → WriteData_wb=32'h44, WriteReg_wb=31.
  - All-zero bubble → RegWrite_wb=0 and no RAM change.
